// File: rtl/seq_bit_serializer_pkg.sv
// Shared constants for the serializer that feeds the serial sequence detector.
package seq_pkg;

  localparam logic IDLE_ENC  = 1'b0;
  localparam logic SHIFT_ENC = 1'b1;

  typedef enum logic {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC
  } state_e;

  localparam logic IDLE_BIT_DEF = 1'b1;

  // Word width consumed by the downstream detector.
  localparam int SEQ_W = 8;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: valid/ready word intake, one bit per enabled clock,
// back-to-back frames without a bubble, and a downstream stall enable.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SEQ_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ser_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic               xfer;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The shifter holds the bits not yet presented, next one at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = ser_en && ((state_q == IDLE) ||
                                (state_q == SHIFT && cnt_q == CNT_W'(1)));
  assign xfer      = din_valid && din_ready;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    if (xfer) begin
      sh_d        = advance(din);
      bit_out_d   = head_bit(din);
      cnt_d       = CNT_W'(WIDTH);
      bit_valid_d = 1'b1;
      busy_d      = 1'b1;
      state_d     = SHIFT;
    end else if (ser_en) begin
      unique case (state_q)
        SHIFT: begin
          if (cnt_q > CNT_W'(1)) begin
            bit_out_d    = head_bit(sh_q);
            sh_d         = advance(sh_q);
            cnt_d        = cnt_q - CNT_W'(1);
            bit_valid_d  = 1'b1;
            frame_done_d = (cnt_q == CNT_W'(2));
          end else begin
            bit_out_d = IDLE_BIT;
            cnt_d     = '0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
        default: begin
          bit_out_d = IDLE_BIT;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      bit_out_q    <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a bit-queue
// reference model supplies expected bits, a negedge monitor pops and compares.
module tb_seq_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         ser_en;
  logic         rdy_m, bo_m, bv_m, fd_m, busy_m;
  logic         rdy_l, bo_l, bv_l, fd_l, busy_l;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .ser_en(ser_en), .bit_out(bo_m), .bit_valid(bv_m), .frame_done(fd_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .ser_en(ser_en), .bit_out(bo_l), .bit_valid(bv_l), .frame_done(fd_l), .busy(busy_l)
  );

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  logic qm[$];
  logic ql[$];
  bit   pres = 1'b0, busy_exp = 1'b0, mon_en = 1'b0, stall_mode = 1'b0;
  logic last_m = 1'b1, last_l = 1'b1;
  logic em, el;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word accepted becomes W queued bits; one bit is
  // presented per enabled edge, and a new word is taken only when none remain.
  always @(posedge clk) begin
    if (rst) begin
      qm.delete();
      ql.delete();
      pres     = 1'b0;
      busy_exp = 1'b0;
      last_m   = 1'b1;
      last_l   = 1'b1;
      mon_en   = 1'b1;
    end else if (ser_en) begin
      if (qm.size() == 0 && din_valid) begin
        for (int i = W - 1; i >= 0; i--) qm.push_back(din[i]);
        for (int i = 0; i < W; i++) ql.push_back(din[i]);
        xfers++;
        pres     = 1'b1;
        busy_exp = 1'b1;
      end else if (qm.size() > 0) begin
        pres = 1'b1;
      end else begin
        pres     = 1'b0;
        busy_exp = 1'b0;
        last_m   = 1'b1;
        last_l   = 1'b1;
      end
    end else begin
      pres = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("bit_valid_msb", bv_m, pres);
      check("bit_valid_lsb", bv_l, pres);
      check("busy_msb", busy_m, busy_exp);
      check("busy_lsb", busy_l, busy_exp);
      if (pres && qm.size() > 0) begin
        em = qm.pop_front();
        el = ql.pop_front();
        last_m = em;
        last_l = el;
        check("bit_out_msb", bo_m, em);
        check("bit_out_lsb", bo_l, el);
        check("frame_done_msb", fd_m, qm.size() == 0);
        check("frame_done_lsb", fd_l, ql.size() == 0);
      end else begin
        check("frame_done_quiet_msb", fd_m, 0);
        check("frame_done_quiet_lsb", fd_l, 0);
        check("bit_out_hold_msb", bo_m, last_m);
        check("bit_out_hold_lsb", bo_l, last_l);
      end
      check("din_ready_msb", rdy_m, ser_en && qm.size() == 0);
      check("din_ready_lsb", rdy_l, ser_en && qm.size() == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds din/din_valid until the model records a transfer (bounded wait).
  task automatic send(input logic [W-1:0] w);
    int start;
    start     = xfers;
    din       = w;
    din_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (stall_mode) ser_en = ($urandom_range(3) != 0);
      tick(1);
      if (xfers != start) break;
    end
    check("send_accepted", xfers - start, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; ser_en = 1'b1;
    tick(2);
    rst = 1'b0;
    check("reset_bit_out", bo_m, 1);
    check("reset_bit_valid", bv_m, 0);
    check("reset_busy", busy_m, 0);

    // Basic frame, then LSB-first pattern.
    send(8'b0010_0100); din_valid = 1'b0; tick(10);
    send(8'b0000_0011); din_valid = 1'b0; tick(10);

    // Back-to-back words held on din_valid.
    send(8'hA5); send(8'h3C); din_valid = 1'b0; tick(10);

    // Three-cycle stall after the third bit.
    send(8'hF0); din_valid = 1'b0; tick(2);
    ser_en = 1'b0; tick(3); ser_en = 1'b1; tick(10);

    // Reset after the fourth bit, new word straight after.
    send(8'h96); din_valid = 1'b0; tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("midreset_busy", busy_m, 0);
    send(8'h3C); din_valid = 1'b0; tick(10);

    // Word offered while another is in flight.
    send(8'hFF); send(8'h55); din_valid = 1'b0; tick(12);

    // Randomised words, stalls and gaps.
    stall_mode = 1'b1;
    for (int k = 0; k < 150; k++) begin
      send(W'($urandom));
      if ($urandom_range(2) == 0) begin
        din_valid = 1'b0;
        ser_en    = 1'b1;
        tick($urandom_range(3));
      end
    end
    stall_mode = 1'b0;
    din_valid  = 1'b0;
    ser_en     = 1'b1;
    tick(20);
    check("drained", qm.size(), 0);
    check("final_busy", busy_m, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
